// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and default sizes for the multi-cycle multiply sequencer.
package mult_seq_ctrl_pkg;

   localparam int MULT_WORD_LEN     = 32;
   localparam int MULT_REG_ADDR_LEN = 5;
   localparam int MULT_CNT_LEN      = 6;

   typedef enum logic [1:0] {
      MULT_IDLE = 2'd0,
      MULT_BUSY = 2'd1,
      MULT_WB   = 2'd2
   } mult_state_e;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// EX-stage / write-back side bundle of the multiply sequencer.
interface mult_seq_ctrl_if
   import mult_seq_ctrl_pkg::*;
#(
   parameter int WORD_LEN     = MULT_WORD_LEN,
   parameter int REG_ADDR_LEN = MULT_REG_ADDR_LEN
) ();

   logic                    start;
   logic                    flush;
   logic [WORD_LEN-1:0]     op_a;
   logic [WORD_LEN-1:0]     op_b;
   logic [REG_ADDR_LEN-1:0] dest_in;
   logic                    stall;
   logic                    busy;
   logic                    wb_req;
   logic                    wb_grant;
   logic [REG_ADDR_LEN-1:0] wb_dest;
   logic [WORD_LEN-1:0]     wb_value;
   logic [WORD_LEN-1:0]     prod_hi;
   logic [WORD_LEN-1:0]     prod_lo;
   logic                    done;

   modport master (
      output start, flush, op_a, op_b, dest_in, wb_grant,
      input  stall, busy, wb_req, wb_dest, wb_value, prod_hi, prod_lo, done
   );

   modport slave (
      input  start, flush, op_a, op_b, dest_in, wb_grant,
      output stall, busy, wb_req, wb_dest, wb_value, prod_hi, prod_lo, done
   );

endinterface

// File: rtl/mult_shift_add_dp.sv
// Shift-add multiply datapath: one partial product per step, with early
// termination once the remaining multiplier bits are all zero.
module mult_shift_add_dp
   import mult_seq_ctrl_pkg::*;
#(
   parameter int WORD_LEN = MULT_WORD_LEN,
   parameter int CNT_LEN  = MULT_CNT_LEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic                  step_i,
   input  logic [WORD_LEN-1:0]   op_a_i,
   input  logic [WORD_LEN-1:0]   op_b_i,
   output logic                  last_iter_o,
   output logic [2*WORD_LEN-1:0] acc_o
);

   logic [2*WORD_LEN-1:0] acc_q,    acc_d;
   logic [2*WORD_LEN-1:0] mcand_q,  mcand_d;
   logic [WORD_LEN-1:0]   mplier_q, mplier_d;
   logic [CNT_LEN-1:0]    cnt_q,    cnt_d;

   // acc_o already contains the current step's partial product so the
   // controller can capture the final product on the exit step itself.
   assign acc_o       = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign last_iter_o = ((mplier_q >> 1) == '0) || (cnt_q == CNT_LEN'(WORD_LEN-1));

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (load_i) begin
         acc_d    = '0;
         mcand_d  = {{WORD_LEN{1'b0}}, op_a_i};
         mplier_d = op_b_i;
         cnt_d    = '0;
      end else if (step_i) begin
         acc_d    = acc_o;
         mcand_d  = {mcand_q[2*WORD_LEN-2:0], 1'b0};
         mplier_d = {1'b0, mplier_q[WORD_LEN-1:1]};
         cnt_d    = cnt_q + CNT_LEN'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle multiply sequencer: freezes the pipeline while the shift-add
// datapath runs, then requests the shared write-back port for the low word.
module mult_seq_ctrl
   import mult_seq_ctrl_pkg::*;
#(
   parameter int WORD_LEN     = MULT_WORD_LEN,
   parameter int REG_ADDR_LEN = MULT_REG_ADDR_LEN,
   parameter int CNT_LEN      = MULT_CNT_LEN
) (
   input  logic           clk,
   input  logic           rst,
   mult_seq_ctrl_if.slave bus
);

   mult_state_e             state_q;
   logic [REG_ADDR_LEN-1:0] dest_q;
   logic                    busy_q;
   logic                    wb_req_q;
   logic [REG_ADDR_LEN-1:0] wb_dest_q;
   logic [WORD_LEN-1:0]     wb_value_q;
   logic [WORD_LEN-1:0]     prod_hi_q;
   logic [WORD_LEN-1:0]     prod_lo_q;
   logic                    done_q;

   logic                    accept;
   logic                    last_iter;
   logic [2*WORD_LEN-1:0]   acc;

   assign accept = (state_q == MULT_IDLE) && bus.start && !bus.flush;

   // Combinational so the issuing instruction is frozen in its first EX cycle.
   assign bus.stall    = (state_q != MULT_IDLE) || (bus.start && !bus.flush);
   assign bus.busy     = busy_q;
   assign bus.wb_req   = wb_req_q;
   assign bus.wb_dest  = wb_dest_q;
   assign bus.wb_value = wb_value_q;
   assign bus.prod_hi  = prod_hi_q;
   assign bus.prod_lo  = prod_lo_q;
   assign bus.done     = done_q;

   mult_shift_add_dp #(
      .WORD_LEN (WORD_LEN),
      .CNT_LEN  (CNT_LEN)
   ) u_dp (
      .clk         (clk),
      .rst         (rst),
      .load_i      (accept),
      .step_i      (state_q == MULT_BUSY),
      .op_a_i      (bus.op_a),
      .op_b_i      (bus.op_b),
      .last_iter_o (last_iter),
      .acc_o       (acc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= MULT_IDLE;
         dest_q     <= '0;
         busy_q     <= 1'b0;
         wb_req_q   <= 1'b0;
         wb_dest_q  <= '0;
         wb_value_q <= '0;
         prod_hi_q  <= '0;
         prod_lo_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            MULT_IDLE: begin
               if (accept) begin
                  state_q <= MULT_BUSY;
                  busy_q  <= 1'b1;
                  dest_q  <= bus.dest_in;
               end
            end
            MULT_BUSY: begin
               if (bus.flush) begin
                  state_q <= MULT_IDLE;
                  busy_q  <= 1'b0;
               end else if (last_iter) begin
                  prod_hi_q <= acc[2*WORD_LEN-1:WORD_LEN];
                  prod_lo_q <= acc[WORD_LEN-1:0];
                  // r0 is never written, so the multiply commits without the port.
                  if (dest_q == '0) begin
                     state_q <= MULT_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= MULT_WB;
                     wb_req_q   <= 1'b1;
                     wb_dest_q  <= dest_q;
                     wb_value_q <= acc[WORD_LEN-1:0];
                  end
               end
            end
            MULT_WB: begin
               if (bus.flush) begin
                  state_q  <= MULT_IDLE;
                  busy_q   <= 1'b0;
                  wb_req_q <= 1'b0;
               end else if (bus.wb_grant) begin
                  state_q  <= MULT_IDLE;
                  busy_q   <= 1'b0;
                  wb_req_q <= 1'b0;
                  done_q   <= 1'b1;
               end
            end
            default: begin
               state_q  <= MULT_IDLE;
               busy_q   <= 1'b0;
               wb_req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl against an arithmetic reference model.
module tb_mult_seq_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   mult_seq_ctrl_if #(.WORD_LEN(32), .REG_ADDR_LEN(5)) bus ();

   mult_seq_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Issuing a multiply while the sequencer is busy would be a pipeline bug.
   always @(posedge clk) begin
      if (!rst && bus.start && bus.busy) begin
         fails++;
         $display("FAIL start_while_busy: start=%0b busy=%0b, required start=0", bus.start, bus.busy);
      end
   end

   function automatic int exp_busy(input logic [31:0] b);
      int n = 1;
      for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
      return n;
   endfunction

   // Runs one multiply from issue to two idle cycles after completion.
   task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                          input int gdly, output int n_busy, output int n_stall,
                          output int n_wb, output int n_done, output logic [4:0] wdest,
                          output logic [31:0] wval, output bit held_ok, output bit tmo);
      int idle = 0;
      bit seen = 0;
      n_busy = 0; n_stall = 0; n_wb = 0; n_done = 0;
      wdest = '0; wval = '0; held_ok = 1; tmo = 1;
      @(negedge clk);
      bus.op_a = a; bus.op_b = b; bus.dest_in = d; bus.flush = 0; bus.start = 1;
      for (int c = 0; c < 300; c++) begin
         #1;
         if (bus.stall) n_stall++;
         if (bus.done) n_done++;
         if (bus.busy) seen = 1;
         if (bus.busy && !bus.wb_req) n_busy++;
         if (bus.wb_req) begin
            if (n_wb == 0) begin
               wdest = bus.wb_dest; wval = bus.wb_value;
            end else if (bus.wb_dest !== wdest || bus.wb_value !== wval || bus.stall !== 1'b1) begin
               held_ok = 0;
            end
            bus.wb_grant = (n_wb == gdly);
            n_wb++;
         end else begin
            bus.wb_grant = 0;
         end
         if (seen && !bus.busy) idle++;
         if (idle == 2) begin
            tmo = 0;
            break;
         end
         @(negedge clk);
         bus.start = 0;
      end
      bus.start = 0;
      bus.wb_grant = 0;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
      @(negedge clk);
      bus.op_a = a; bus.op_b = b; bus.dest_in = d; bus.flush = 0; bus.start = 1;
      @(negedge clk);
      bus.start = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (3) @(negedge clk);
      #1;
      tests++;
      if ({bus.stall, bus.busy, bus.wb_req, bus.done} !== 4'b0 || bus.wb_dest !== 5'd0 ||
          bus.wb_value !== 32'd0 || bus.prod_hi !== 32'd0 || bus.prod_lo !== 32'd0)
         begin fails++; $display("FAIL reset_outputs: stall/busy/req/done=%b hi=%h lo=%h, required all 0",
            {bus.stall, bus.busy, bus.wb_req, bus.done}, bus.prod_hi, bus.prod_lo); end
      rst = 0;
   endtask

   task automatic test_basic;
      int nb, ns, nw, nd; logic [4:0] wd; logic [31:0] wv; bit ho, to;
      do_mult(32'd3, 32'd5, 5'd4, 0, nb, ns, nw, nd, wd, wv, ho, to);
      tests++; if (to)      begin fails++; $display("FAIL basic_timeout: no completion"); end
      tests++; if (nb != 3) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 3", nb); end
      tests++; if (ns != 5) begin fails++; $display("FAIL basic_stall_cycles: got %0d want 5", ns); end
      tests++; if (nw != 1) begin fails++; $display("FAIL basic_wb_cycles: got %0d want 1", nw); end
      tests++; if (nd != 1) begin fails++; $display("FAIL basic_done: got %0d want 1", nd); end
      tests++; if (wd !== 5'd4 || wv !== 32'd15)
         begin fails++; $display("FAIL basic_wb: dest=%0d val=%0d want 4/15", wd, wv); end
      tests++; if (bus.prod_hi !== 32'd0 || bus.prod_lo !== 32'd15)
         begin fails++; $display("FAIL basic_prod: %h_%h want 0_f", bus.prod_hi, bus.prod_lo); end
   endtask

   task automatic test_extremes;
      int nb, ns, nw, nd; logic [4:0] wd; logic [31:0] wv; bit ho, to;
      do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, nb, ns, nw, nd, wd, wv, ho, to);
      tests++; if (to || nb != 32) begin fails++; $display("FAIL max_busy_cycles: got %0d tmo=%0b want 32", nb, to); end
      tests++; if (bus.prod_hi !== 32'hFFFF_FFFE || bus.prod_lo !== 32'h0000_0001)
         begin fails++; $display("FAIL max_prod: %h_%h want fffffffe_00000001", bus.prod_hi, bus.prod_lo); end
      do_mult(32'h1234_5678, 32'd0, 5'd7, 0, nb, ns, nw, nd, wd, wv, ho, to);
      tests++; if (to || nb != 1 || wv !== 32'd0 || wd !== 5'd7 || nd != 1)
         begin fails++; $display("FAIL zero_b: busy=%0d val=%h dest=%0d done=%0d want 1/0/7/1", nb, wv, wd, nd); end
      do_mult(32'd3, 32'h8000_0000, 5'd2, 0, nb, ns, nw, nd, wd, wv, ho, to);
      tests++; if (to || nb != 32) begin fails++; $display("FAIL msb_b_busy: got %0d want 32", nb); end
      tests++; if (bus.prod_hi !== 32'd1 || bus.prod_lo !== 32'h8000_0000)
         begin fails++; $display("FAIL msb_b_prod: %h_%h want 00000001_80000000", bus.prod_hi, bus.prod_lo); end
   endtask

   task automatic test_grant_wait;
      int nb, ns, nw, nd; logic [4:0] wd; logic [31:0] wv; bit ho, to;
      do_mult(32'd3, 32'd5, 5'd9, 4, nb, ns, nw, nd, wd, wv, ho, to);
      tests++; if (to || nw != 5) begin fails++; $display("FAIL grant_wait_wb_cycles: got %0d want 5", nw); end
      tests++; if (!ho) begin fails++; $display("FAIL grant_wait_hold: req/dest/value/stall changed, want stable"); end
      tests++; if (ns != 9 || nd != 1 || wd !== 5'd9 || wv !== 32'd15)
         begin fails++; $display("FAIL grant_wait_result: stall=%0d done=%0d dest=%0d val=%0d want 9/1/9/15", ns, nd, wd, wv); end
   endtask

   task automatic test_back_to_back;
      bit saw_req = 0, got = 0;
      issue(32'd6, 32'd7, 5'd0);
      for (int c = 0; c < 40; c++) begin
         #1;
         if (bus.wb_req) saw_req = 1;
         if (bus.done) begin got = 1; break; end
         @(negedge clk);
      end
      tests++; if (!got || saw_req || bus.busy !== 1'b0 || bus.prod_lo !== 32'd42 || bus.prod_hi !== 32'd0)
         begin fails++; $display("FAIL dest0_commit: done=%0b req=%0b busy=%0b lo=%0d want 1/0/0/42", got, saw_req, bus.busy, bus.prod_lo); end
      bus.op_a = 32'd11; bus.op_b = 32'd13; bus.dest_in = 5'd0; bus.start = 1;
      #1;
      tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL b2b_issue_stall: got %0b want 1", bus.stall); end
      @(negedge clk);
      bus.start = 0;
      #1;
      tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: busy=%0b want 1", bus.busy); end
      got = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.wb_req) saw_req = 1;
         if (bus.done) begin got = 1; break; end
         @(negedge clk); #1;
      end
      tests++; if (!got || saw_req || bus.prod_lo !== 32'd143)
         begin fails++; $display("FAIL b2b_result: done=%0b req=%0b lo=%0d want 1/0/143", got, saw_req, bus.prod_lo); end
   endtask

   task automatic test_flush;
      logic [31:0] hi0, lo0;
      bit bad = 0, got = 0;
      @(negedge clk);
      bus.start = 1; bus.flush = 1; bus.dest_in = 5'd3;
      #1;
      tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL flushed_start_stall: got %0b want 0", bus.stall); end
      @(negedge clk); #1;
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL flushed_start_idle: busy=%0b want 0", bus.busy); end
      bus.start = 0; bus.flush = 0;
      hi0 = bus.prod_hi; lo0 = bus.prod_lo;
      issue(32'd9, 32'h0000_FFFF, 5'd3);
      repeat (3) @(negedge clk);
      bus.flush = 1;
      @(negedge clk);
      bus.flush = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (bus.busy || bus.wb_req || bus.done || bus.stall || bus.prod_hi !== hi0 || bus.prod_lo !== lo0) bad = 1;
         @(negedge clk);
      end
      tests++; if (bad) begin fails++; $display("FAIL flush_busy_abort: busy/req/done/stall active or prod changed, want idle and prod %h_%h", hi0, lo0); end
      issue(32'd5, 32'd3, 5'd9);
      for (int c = 0; c < 40; c++) begin
         #1;
         if (bus.wb_req) begin got = 1; break; end
         @(negedge clk);
      end
      tests++; if (!got || bus.prod_lo !== 32'd15 || bus.prod_hi !== 32'd0)
         begin fails++; $display("FAIL flush_wb_entry: req=%0b lo=%0d want 1/15", got, bus.prod_lo); end
      bus.flush = 1; bus.wb_grant = 0;
      @(negedge clk);
      bus.flush = 0;
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (bus.busy || bus.wb_req || bus.done || bus.prod_lo !== 32'd15) bad = 1;
         @(negedge clk);
      end
      tests++; if (bad) begin fails++; $display("FAIL flush_wb_abort: busy/req/done active or prod_lo changed, want idle, lo=15"); end
   endtask

   task automatic test_reset_mid;
      bit bad = 0;
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
      repeat (9) @(negedge clk);
      rst = 1;
      @(negedge clk); #1;
      tests++; if ({bus.stall, bus.busy, bus.wb_req, bus.done} !== 4'b0 || bus.prod_hi !== 32'd0 ||
                   bus.prod_lo !== 32'd0 || bus.wb_value !== 32'd0 || bus.wb_dest !== 5'd0)
         begin fails++; $display("FAIL reset_mid_busy: stall/busy/req/done=%b hi=%h lo=%h, want all 0",
            {bus.stall, bus.busy, bus.wb_req, bus.done}, bus.prod_hi, bus.prod_lo); end
      rst = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); #1;
         if (bus.busy || bus.wb_req || bus.done) bad = 1;
      end
      tests++; if (bad) begin fails++; $display("FAIL reset_mid_resume: activity after reset, want idle"); end
   endtask

   task automatic test_random;
      int nb, ns, nw, nd; logic [4:0] wd; logic [31:0] wv; bit ho, to;
      logic [31:0] a, b; logic [4:0] d; int g, ewb; logic [63:0] p;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         d = 5'($urandom_range(0, 31));
         if (i % 6 == 0) d = 5'd0;
         g = $urandom_range(0, 3);
         p = 64'(a) * 64'(b);
         ewb = (d == 5'd0) ? 0 : g + 1;
         do_mult(a, b, d, g, nb, ns, nw, nd, wd, wv, ho, to);
         tests++; if (to || nb != exp_busy(b) || nw != ewb || ns != 1 + exp_busy(b) + ewb || nd != 1 || !ho)
            begin fails++; $display("FAIL rand_timing[%0d]: b=%h busy=%0d wb=%0d stall=%0d done=%0d want %0d/%0d/%0d/1",
               i, b, nb, nw, ns, nd, exp_busy(b), ewb, 1 + exp_busy(b) + ewb); end
         tests++; if ({bus.prod_hi, bus.prod_lo} !== p)
            begin fails++; $display("FAIL rand_prod[%0d]: %h*%h got %h_%h want %h", i, a, b, bus.prod_hi, bus.prod_lo, p); end
         if (d != 5'd0) begin
            tests++; if (wd !== d || wv !== p[31:0])
               begin fails++; $display("FAIL rand_wb[%0d]: dest=%0d val=%h want %0d/%h", i, wd, wv, d, p[31:0]); end
         end
      end
   endtask

   initial begin
      bus.start = 0; bus.flush = 0; bus.op_a = '0; bus.op_b = '0; bus.dest_in = '0; bus.wb_grant = 0;
      test_reset();
      test_basic();
      test_extremes();
      test_grant_wait();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
